ysyx_22040088_ifu: RTL and testbench

YSYX_22040088_IFU -- requirements
Module: ysyx_22040088_ifu

---
 rtl/ysyx_22040088_ifu.sv | 164 ++++++++++++++++
 tb/tb_ysyx_22040088_ifu.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040088_ifu.sv
// rtl/ysyx_22040088_ifu.sv - instruction fetch unit: one-outstanding fetch FSM with redirect handling
//
// Purpose:
//   Issues one instruction fetch at a time, waits for the response, then
//   presents the word to the decoder. Redirects from downstream replace the
//   fetch PC. An in-flight response made stale by a redirect is dropped.
//
// Ports:
//   clk, rst                        single clock, synchronous active-high reset
//   redirect_valid, redirect_pc     one-cycle PC change request and its target
//   imem_req_valid/ready, imem_addr fetch request channel
//   imem_rsp_valid, imem_rsp_data   fetch response (one per accepted request)
//   inst_valid/ready, inst, inst_pc instruction channel toward the decoder
//   fetch_misalign                  sticky misaligned-target flag
//
// Configuration:
//   YSYX_22040088_IFU_MISALIGN_CHK_EN  defined: a redirect with target[1:0]!=0
//   sets fetch_misalign and halts fetching until reset. Undefined: the flag is
//   always 0 and target[1:0] is forced to 2'b00.

module ysyx_22040088_ifu #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [63:0] inst_pc,
    output logic        fetch_misalign
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] pend_pc_q, pend_pc_d;
    logic        pend_q, pend_d;
    logic        drop_q, drop_d;
    logic [31:0] inst_q, inst_d;
    logic [63:0] inst_pc_q, inst_pc_d;
    logic        misalign_q, misalign_d;

    logic [63:0] tgt_pc;
    logic        redir_bad;
    logic        redir;

`ifdef YSYX_22040088_IFU_MISALIGN_CHK_EN
    assign tgt_pc    = redirect_pc;
    assign redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
    logic unused_low_bits;
    assign unused_low_bits = ^redirect_pc[1:0];
    assign tgt_pc    = {redirect_pc[63:2], 2'b00};
    assign redir_bad = 1'b0;
`endif

    // A misaligned redirect is never applied; it halts the fetcher instead.
    assign redir = redirect_valid && !redir_bad && !misalign_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            pend_pc_q  <= RESET_PC;
            pend_q     <= 1'b0;
            drop_q     <= 1'b0;
            inst_q     <= 32'h0000_0013;
            inst_pc_q  <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_pc_q  <= pend_pc_d;
            pend_q     <= pend_d;
            drop_q     <= drop_d;
            inst_q     <= inst_d;
            inst_pc_q  <= inst_pc_d;
            misalign_q <= misalign_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_pc_d  = pend_pc_q;
        pend_d     = pend_q;
        drop_d     = drop_q;
        inst_d     = inst_q;
        inst_pc_d  = inst_pc_q;
        misalign_d = misalign_q | redir_bad;
        unique case (state_q)
            S_REQ: begin
                // The address must stay stable until accepted, so the target
                // is parked and applied once the stale response is discarded.
                if (redir) begin
                    pend_d    = 1'b1;
                    pend_pc_d = tgt_pc;
                    drop_d    = 1'b1;
                end
                if (imem_req_valid && imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // Applying the target now supersedes any parked one.
                if (redir) begin
                    pc_d   = tgt_pc;
                    pend_d = 1'b0;
                    drop_d = 1'b1;
                end
                if (imem_rsp_valid) begin
                    if (drop_q || redir) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                        if (pend_q && !redir) begin
                            pc_d   = pend_pc_q;
                            pend_d = 1'b0;
                        end
                    end else begin
                        inst_d    = imem_rsp_data;
                        inst_pc_d = pc_q;
                        state_d   = S_OUT;
                    end
                end
            end
            S_OUT: begin
                if (redir) begin
                    pc_d    = tgt_pc;
                    state_d = S_REQ;
                end else if (inst_ready) begin
                    pc_d    = pc_q + 64'd4;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    // Output logic
    always_comb begin
        imem_req_valid = (state_q == S_REQ) && !rst && !misalign_q;
        inst_valid     = (state_q == S_OUT) && !rst && !misalign_q;
    end

    assign imem_addr      = pc_q;
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;
    assign fetch_misalign = misalign_q;

endmodule

// File: tb/tb_ysyx_22040088_ifu.sv
// tb/tb_ysyx_22040088_ifu.sv - self-checking bench for ysyx_22040088_ifu

module tb_ysyx_22040088_ifu;

    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [63:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        fetch_misalign;

    int checks = 0;
    int errors = 0;

    ysyx_22040088_ifu #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .fetch_misalign (fetch_misalign)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    // Memory contents as a pure function of address.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'h5A5A_0F0F;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; redirect_valid = 1'b0; imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0; inst_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; redirect_valid = 1'b0; imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0; inst_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got %0b exp 0", imem_req_valid); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid got %0b exp 0", inst_valid); end
        checks++; if (fetch_misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign got %0b exp 0", fetch_misalign); end
        checks++; if (inst !== 32'h0000_0013) begin errors++; $display("FAIL reset_inst got %h exp 00000013", inst); end
        checks++; if (inst_pc !== RESET_PC) begin errors++; $display("FAIL reset_inst_pc got %h exp %h", inst_pc, RESET_PC); end
        rst = 1'b0; imem_req_ready = 1'b0; inst_ready = 1'b0;
        #1;
        checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL release_req_valid got %0b exp 1", imem_req_valid); end
        checks++; if (imem_addr !== RESET_PC) begin errors++; $display("FAIL release_addr got %h exp %h", imem_addr, RESET_PC); end
    endtask

    task automatic test_latency();
        apply_reset();
        imem_req_ready = 1'b1;
        checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 64'h8000_0000) begin errors++; $display("FAIL lat_c0 got v=%0b a=%h exp v=1 a=80000000", imem_req_valid, imem_addr); end
        @(negedge clk);
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0093;
        checks++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0) begin errors++; $display("FAIL lat_c1 got iv=%0b rv=%0b exp 0 0", inst_valid, imem_req_valid); end
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL lat_c2_valid got %0b exp 1", inst_valid); end
        checks++; if (inst !== 32'h0000_0093 || inst_pc !== 64'h8000_0000) begin errors++; $display("FAIL lat_c2_data got %h@%h exp 00000093@80000000", inst, inst_pc); end
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 64'h8000_0004) begin errors++; $display("FAIL lat_next_req got v=%0b a=%h exp v=1 a=80000004", imem_req_valid, imem_addr); end
    endtask

    task automatic test_req_stall();
        for (int i = 0; i < 3; i++) begin
            checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 64'h8000_0004) begin errors++; $display("FAIL req_stall_%0d got v=%0b a=%h exp v=1 a=80000004", i, imem_req_valid, imem_addr); end
            @(negedge clk);
        end
        imem_req_ready = 1'b1;
        checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 64'h8000_0004) begin errors++; $display("FAIL req_stall_acc got v=%0b a=%h exp v=1 a=80000004", imem_req_valid, imem_addr); end
        @(negedge clk);
        imem_req_ready = 1'b0;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL req_stall_wait got %0b exp 0", imem_req_valid); end
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0113;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
    endtask

    task automatic test_out_stall();
        for (int i = 0; i < 4; i++) begin
            checks++; if (inst_valid !== 1'b1 || inst !== 32'h0000_0113 || inst_pc !== 64'h8000_0004 || imem_req_valid !== 1'b0) begin
                errors++; $display("FAIL out_stall_%0d got iv=%0b %h@%h rv=%0b exp iv=1 00000113@80000004 rv=0", i, inst_valid, inst, inst_pc, imem_req_valid);
            end
            @(negedge clk);
        end
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 64'h8000_0008) begin errors++; $display("FAIL out_stall_next got v=%0b a=%h exp v=1 a=80000008", imem_req_valid, imem_addr); end
    endtask

    task automatic test_redirect_wait();
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h8000_0100;
        @(negedge clk);
        redirect_valid = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_0BAD;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rw_iv1 got %0b exp 0", inst_valid); end
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rw_iv2 got %0b exp 0", inst_valid); end
        checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 64'h8000_0100) begin errors++; $display("FAIL rw_next got v=%0b a=%h exp v=1 a=80000100", imem_req_valid, imem_addr); end
    endtask

    task automatic test_redirect_out();
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0010_0093;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 64'h8000_0100) begin errors++; $display("FAIL ro_out got iv=%0b pc=%h exp iv=1 pc=80000100", inst_valid, inst_pc); end
        inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h8000_0200;
        @(negedge clk);
        inst_ready = 1'b0; redirect_valid = 1'b0;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL ro_iv got %0b exp 0", inst_valid); end
        checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 64'h8000_0200) begin errors++; $display("FAIL ro_next got v=%0b a=%h exp v=1 a=80000200", imem_req_valid, imem_addr); end
    endtask

    task automatic test_redirect_req();
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0300;
        @(negedge clk);
        redirect_valid = 1'b0;
        checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 64'h8000_0200) begin errors++; $display("FAIL rq_hold got v=%0b a=%h exp v=1 a=80000200", imem_req_valid, imem_addr); end
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1234_5678;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rq_drop got iv=%0b exp 0", inst_valid); end
        checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 64'h8000_0300) begin errors++; $display("FAIL rq_next got v=%0b a=%h exp v=1 a=80000300", imem_req_valid, imem_addr); end
    endtask

    task automatic test_misalign();
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h8000_0102;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
        @(negedge clk);
        redirect_valid = 1'b0; imem_rsp_valid = 1'b0;
`ifdef YSYX_22040088_IFU_MISALIGN_CHK_EN
        imem_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (fetch_misalign !== 1'b1 || imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
                errors++; $display("FAIL ma_halt_%0d got m=%0b rv=%0b iv=%0b exp 1 0 0", i, fetch_misalign, imem_req_valid, inst_valid);
            end
            @(negedge clk);
        end
        apply_reset();
        checks++; if (fetch_misalign !== 1'b0 || imem_req_valid !== 1'b1) begin errors++; $display("FAIL ma_clear got m=%0b rv=%0b exp 0 1", fetch_misalign, imem_req_valid); end
`else
        checks++; if (fetch_misalign !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL ma_flag got m=%0b iv=%0b exp 0 0", fetch_misalign, inst_valid); end
        checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 64'h8000_0100) begin errors++; $display("FAIL ma_next got v=%0b a=%h exp v=1 a=80000100", imem_req_valid, imem_addr); end
`endif
    endtask

    task automatic test_reset_mid();
        apply_reset();
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hFFFF_FFFF;
        #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_addr !== RESET_PC) begin errors++; $display("FAIL rm_req got v=%0b a=%h exp v=1 a=%h", imem_req_valid, imem_addr, RESET_PC); end
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        checks++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== RESET_PC) begin
            errors++; $display("FAIL rm_ignore got iv=%0b rv=%0b a=%h exp iv=0 rv=1 a=%h", inst_valid, imem_req_valid, imem_addr, RESET_PC);
        end
    endtask

    // Transaction-level model: every delivered instruction must carry the
    // next PC of the program-order stream (sequential +4, restarted at each
    // redirect target) and the memory word stored at that PC.
    task automatic test_random();
        logic [63:0] exp_pc, tgt, out_addr, p_addr, p_ipc;
        logic [31:0] p_inst;
        logic        outstanding, pv_req, pr_ready, pv_inst, pr_iready, p_redir;
        int          delay, idle, delivered;
        apply_reset();
        exp_pc = RESET_PC; outstanding = 1'b0; delay = 0; idle = 0; delivered = 0;
        pv_req = 1'b0; pr_ready = 1'b0; pv_inst = 1'b0; pr_iready = 1'b0; p_redir = 1'b0;
        p_addr = '0; p_ipc = '0; p_inst = '0; out_addr = '0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (pv_req && !pr_ready) begin
                checks++; if (imem_req_valid !== 1'b1 || imem_addr !== p_addr) begin errors++; $display("FAIL rnd_req_stable c=%0d got v=%0b a=%h exp v=1 a=%h", c, imem_req_valid, imem_addr, p_addr); end
            end
            if (pv_inst && !pr_iready && !p_redir) begin
                checks++; if (inst_valid !== 1'b1 || inst !== p_inst || inst_pc !== p_ipc) begin errors++; $display("FAIL rnd_inst_stable c=%0d got v=%0b %h@%h exp v=1 %h@%h", c, inst_valid, inst, inst_pc, p_inst, p_ipc); end
            end
            if (inst_valid && imem_req_valid) begin
                checks++; errors++; $display("FAIL rnd_both_valid c=%0d got 1 1 exp not both", c);
            end
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
            if (outstanding) begin
                delay--;
                if (delay == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_word(out_addr);
                    outstanding    = 1'b0;
                end
            end
            imem_req_ready = $urandom_range(0, 1) == 1;
            inst_ready     = $urandom_range(0, 2) != 0;
            redirect_valid = $urandom_range(0, 15) == 0;
            tgt = RESET_PC + 64'($urandom_range(0, 1023)) * 64'd4;
`ifndef YSYX_22040088_IFU_MISALIGN_CHK_EN
            tgt = tgt + 64'($urandom_range(0, 3));
`endif
            redirect_pc = tgt;
            if (imem_req_valid && imem_req_ready) begin
                outstanding = 1'b1;
                out_addr    = imem_addr;
                delay       = $urandom_range(1, 3);
            end
            if (inst_valid && inst_ready) begin
                checks++; if (inst_pc !== exp_pc || inst !== mem_word(exp_pc)) begin
                    errors++; $display("FAIL rnd_deliver c=%0d got %h@%h exp %h@%h", c, inst, inst_pc, mem_word(exp_pc), exp_pc);
                end
                exp_pc = exp_pc + 64'd4;
                delivered++;
                idle = 0;
            end else begin
                idle++;
            end
            if (redirect_valid) exp_pc = tgt & ~64'h3;
            if (idle > 200) begin
                checks++; errors++; $display("FAIL rnd_progress c=%0d got no delivery for %0d cycles exp <=200", c, idle);
                break;
            end
            pv_req = imem_req_valid; pr_ready = imem_req_ready; p_addr = imem_addr;
            pv_inst = inst_valid; pr_iready = inst_ready; p_redir = redirect_valid;
            p_inst = inst; p_ipc = inst_pc;
        end
        redirect_valid = 1'b0; imem_rsp_valid = 1'b0; imem_req_ready = 1'b0; inst_ready = 1'b0;
        checks++; if (delivered < 100) begin errors++; $display("FAIL rnd_count got %0d exp >=100", delivered); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_req_stall();
        test_out_stall();
        test_redirect_wait();
        test_redirect_out();
        test_redirect_req();
        test_misalign();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
